ram_dp_async_read: RTL and testbench

- Simple dual-port RAM: one synchronous write port, one independent asynchronous (combinational) read port.
- Used as a small register-file / scratch buffer where the reader needs the stored word in the same cycle it presents the address.
- Single clock domain.
- Asynchronous active-low reset clears the whole array.

---
 rtl/ram_dp_async_read.sv | 56 +++++
 tb/tb_ram_dp_async_read.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_async_read.sv
// Simple dual-port RAM: one clocked write port and one combinational read port.
// An asynchronous active-low reset clears every word of the array.
module ram_dp_async_read #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 16,
    localparam int DEPTH_LOG = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_n,
    input  logic [DEPTH_LOG-1:0] addr_wr,
    input  logic [WIDTH-1:0]     data_wr,
    input  logic [DEPTH_LOG-1:0] addr_rd,
    output logic [WIDTH-1:0]     data_rd
);

    localparam bit POW2 = (DEPTH == (1 << DEPTH_LOG));

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_in_range;
    logic             w_rd_in_range;
    logic             w_wr_fire;

    // With a power-of-two depth every address is legal, so no range compare is built.
    generate
        if (POW2) begin : g_full_range
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_partial_range
            assign w_wr_in_range = (int'(addr_wr) < DEPTH);
            assign w_rd_in_range = (int'(addr_rd) < DEPTH);
        end
    endgenerate

    // An X/Z on we_n never compares equal to 0, so it cannot trigger a write.
    assign w_wr_fire = (we_n === 1'b0) && w_wr_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[addr_wr] <= data_wr;
        end
    end

    // No bypass of data_wr: the read port only ever sees committed storage.
    always_comb begin
        data_rd = '0;
        if (w_rd_in_range) begin
            data_rd = r_mem[addr_rd];
        end
    end

endmodule

// File: tb/tb_ram_dp_async_read.sv
// Directed bench for ram_dp_async_read: reset clearing, fill, overwrite, hold,
// read-during-write ordering and mid-run reset.
module tb_ram_dp_async_read;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             rst_n;
    logic             we_n;
    logic [AW-1:0]    addr_wr;
    logic [WIDTH-1:0] data_wr;
    logic [AW-1:0]    addr_rd;
    logic [WIDTH-1:0] data_rd;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    logic [WIDTH-1:0] fill_tbl [DEPTH] = '{
        8'h3A, 8'hC5, 8'h01, 8'hFE, 8'h80, 8'h7F, 8'h55, 8'hAA,
        8'h96, 8'h69, 8'h0F, 8'hF0, 8'hE1, 8'h1E, 8'hB4, 8'h4B
    };
    logic [AW-1:0] ovw_addr [16] = '{
        4'd3, 4'd8, 4'd3, 4'd14, 4'd0, 4'd9, 4'd15, 4'd6,
        4'd1, 4'd12, 4'd7, 4'd2, 4'd11, 4'd4, 4'd5, 4'd10
    };

    ram_dp_async_read #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_n   (we_n),
        .addr_wr(addr_wr),
        .data_wr(data_wr),
        .addr_rd(addr_rd),
        .data_rd(data_rd)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write one word and check it is visible just after the edge.
    task automatic drive_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        addr_wr = a;
        data_wr = d;
        addr_rd = a;
        we_n    = 1'b0;
        @(posedge clk);
        #1;
        check_eq("write_visible", data_rd, d);
        model[a] = d;
        we_n = 1'b1;
    endtask

    // Sweep all addresses against the model through the expected queue.
    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < DEPTH; i++) begin
            addr_rd = AW'(i);
            #1;
            check_eq(tag, data_rd, exp_q.pop_front());
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        we_n    = 1'b1;
        addr_wr = '0;
        data_wr = '0;
        addr_rd = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset held for 2 cycles, with a write attempt that must be ignored.
        @(negedge clk);
        we_n    = 1'b0;
        addr_wr = 4'd3;
        data_wr = 8'h77;
        @(negedge clk);
        @(negedge clk);
        we_n = 1'b1;
        sweep("reset_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sweep("post_release_sweep");

        // Sequential fill and retention.
        for (int i = 0; i < DEPTH; i++) drive_write(AW'(i), fill_tbl[i]);
        sweep("fill_sweep");

        // Overwrite: 0x0A on odd, 0x05 on even addresses.
        for (int i = 0; i < 16; i++)
            drive_write(ovw_addr[i], ovw_addr[i][0] ? 8'h0A : 8'h05);
        sweep("overwrite_sweep");

        // we_n high must hold the stored word.
        drive_write(4'd7, 8'h3C);
        @(negedge clk);
        addr_wr = 4'd7;
        data_wr = 8'hFF;
        we_n    = 1'b1;
        addr_rd = 4'd7;
        repeat (4) @(posedge clk);
        #1;
        check_eq("hold_we_n_high", data_rd, 8'h3C);

        // Same-address read during write: old before edge, new after.
        drive_write(4'd4, 8'h11);
        drive_write(4'd5, 8'h5D);
        @(negedge clk);
        addr_wr = 4'd4;
        data_wr = 8'h22;
        addr_rd = 4'd4;
        we_n    = 1'b0;
        #1;
        check_eq("rdw_before_edge", data_rd, 8'h11);
        @(posedge clk);
        #1;
        check_eq("rdw_after_edge", data_rd, 8'h22);
        model[4] = 8'h22;
        @(negedge clk);
        data_wr = 8'h33;
        addr_rd = 4'd5;
        #1;
        check_eq("other_addr_before", data_rd, 8'h5D);
        @(posedge clk);
        #1;
        check_eq("other_addr_after", data_rd, 8'h5D);
        model[4] = 8'h33;
        we_n    = 1'b1;
        addr_rd = 4'd4;
        #1;
        check_eq("other_write_landed", data_rd, 8'h33);

        // Combinational read tracks addr_rd changes.
        addr_rd = 4'd0;
        #1;
        check_eq("comb_read_addr0", data_rd, model[0]);
        addr_rd = 4'd15;
        #1;
        check_eq("comb_read_addr15", data_rd, model[15]);

        // Mid-run reset between edges, with a concurrent write attempt.
        @(posedge clk);
        #2;
        addr_rd = 4'd9;
        #1;
        check_eq("pre_reset_addr9", data_rd, model[9]);
        we_n    = 1'b0;
        addr_wr = 4'd9;
        data_wr = 8'hEE;
        rst_n   = 1'b0;
        #1;
        check_eq("reset_immediate_addr9", data_rd, 8'h00);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(posedge clk);
        #1;
        check_eq("write_during_reset", data_rd, 8'h00);
        @(negedge clk);
        we_n = 1'b1;
        sweep("mid_reset_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        addr_rd = 4'd9;
        #1;
        check_eq("after_release_addr9", data_rd, 8'h00);
        drive_write(4'd2, 8'h42);
        sweep("final_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
